neuron_array: RTL

NEURON_ARRAY -- requirements
Module: neuron_array

---
 rtl/neuron_array.sv | 97 +++++++++
 1 files changed

// File: rtl/neuron_array.sv
// rtl/neuron_array.sv - K-channel serial multiply-accumulate neuron with saturation and optional ReLU
module neuron_array #(
    parameter int N    = 4,
    parameter int M    = 18,
    parameter int K    = 2,
    parameter int RELU = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in,
    input  logic [8*K-1:0]   weight,
    input  logic [M*K-1:0]   bias,
    output logic [M*K-1:0]   out,
    output logic             ready,
    output logic             busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic signed [M-1:0] SAT_MAX = {1'b0, {(M-1){1'b1}}};
    localparam logic signed [M-1:0] SAT_MIN = {1'b1, {(M-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACT  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         count_q;
    logic signed [M-1:0]   acc_q [K];
    logic signed [M-1:0]   acc_d [K];
    logic signed [15:0]    prod_d [K];
    logic signed [M:0]     sum_d [K];
    logic [M*K-1:0]        out_q;
    logic                  ready_q;

    // One extra guard bit exposes overflow; a disagreement with the sign bit means clamp.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            prod_d[k] = $signed(in) * $signed(weight[8*k +: 8]);
            sum_d[k]  = {acc_q[k][M-1], acc_q[k]} + {{(M+1-16){prod_d[k][15]}}, prod_d[k]};
            acc_d[k]  = sum_d[k][M-1:0];
            if (sum_d[k][M] != sum_d[k][M-1]) begin
                acc_d[k] = sum_d[k][M] ? SAT_MIN : SAT_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            for (int k = 0; k < K; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < K; k++) begin
                            acc_q[k] <= bias[M*k +: M];
                        end
                        count_q <= '0;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    for (int k = 0; k < K; k++) begin
                        acc_q[k] <= acc_d[k];
                    end
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q <= ACT;
                    end
                end
                ACT: begin
                    for (int k = 0; k < K; k++) begin
                        out_q[M*k +: M] <= ((RELU != 0) && acc_q[k][M-1]) ? '0 : acc_q[k];
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = (state_q == ACC) || (state_q == ACT);

endmodule
